// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, padder state encoding and block-size helper.
// Used by both the padder and the hasher.
package sha256_pkg;

  localparam logic [31:0] SHA256_PAD_MARKER = 32'h8000_0000;
  localparam int SHA256_BLOCK_WORDS = 16;

  typedef enum logic [2:0] {
    PAD_IDLE,
    PAD_WAIT,
    PAD_CAP,
    PAD_NEXT,
    PAD_FILL,
    PAD_DONE
  } pad_state_e;

  // Padded length in words:
  // message + marker + two length words, rounded up to a whole block.
  function automatic logic [15:0] sha256_pad_total(input logic [15:0] n);
    return (n + 16'(SHA256_BLOCK_WORDS + 2))
         & ~16'(SHA256_BLOCK_WORDS - 1);
  endfunction

endpackage

// File: rtl/sha256_pad_gen.sv
// Padding word generator: given message length N and output index j,
// returns the marker, zero fill, or bit-length word.
module sha256_pad_gen
  import sha256_pkg::*;
(
  input  logic [15:0] num_words,
  input  logic [15:0] idx,
  output logic [31:0] pad_word
);

  logic [15:0] total;

  assign total = sha256_pad_total(num_words);

  // Length high word and fill are zero; only marker and length low differ.
  always_comb begin
    pad_word = '0;
    unique case (1'b1)
      (idx == num_words):      pad_word = SHA256_PAD_MARKER;
      (idx == total - 16'd1):  pad_word = {11'b0, num_words, 5'b0};
      default:                 pad_word = '0;
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: copies N words and appends padding in memory.
// Define SHA256_PADDER_BSWAP_EN to byte-reverse copied message words.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [15:0] num_words,
  output logic        done,
  output logic        err,
  output logic [7:0]  block_count,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  pad_state_e  state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] msg_q, msg_d;
  logic [15:0] out_q, out_d;
  logic [15:0] i_q, i_d;
  logic [15:0] j_q, j_d;
  logic [15:0] p_q, p_d;
  logic        bad_q, bad_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [15:0] pad_idx;
  logic [31:0] pad_word;
  logic [31:0] copy_word;
  logic [15:0] total_in;
  logic        n_bad;

  assign mem_clk        = clk;
  assign done           = done_q;
  assign err            = err_q;
  assign block_count    = bcnt_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

  assign total_in = sha256_pad_total(num_words);
  assign n_bad    = (num_words == 16'd0)
                 || (num_words > 16'(MAX_WORDS));
  assign pad_idx  = (state_q == PAD_NEXT) ? n_q : j_q;

`ifdef SHA256_PADDER_BSWAP_EN
  assign copy_word = {mem_read_data[7:0],   mem_read_data[15:8],
                      mem_read_data[23:16], mem_read_data[31:24]};
`else
  assign copy_word = mem_read_data;
`endif

  sha256_pad_gen u_pad_gen (
    .num_words (n_q),
    .idx       (pad_idx),
    .pad_word  (pad_word)
  );

  // State and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAD_IDLE;
      n_q     <= '0;
      msg_q   <= '0;
      out_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      i_q     <= i_d;
      j_q     <= j_d;
      p_q     <= p_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bcnt_q  <= bcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read/capture/write copy loop, then one pad write per cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    msg_d   = msg_q;
    out_d   = out_q;
    i_d     = i_q;
    j_d     = j_q;
    p_d     = p_q;
    bad_d   = bad_q;
    done_d  = done_q;
    err_d   = err_q;
    bcnt_d  = bcnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      PAD_IDLE: begin
        if (start) begin
          n_d   = num_words;
          msg_d = message_addr;
          out_d = output_addr;
          i_d   = '0;
          if (n_bad) begin
            bad_d   = 1'b1;
            bcnt_d  = '0;
            state_d = PAD_DONE;
          end else begin
            bad_d   = 1'b0;
            p_d     = total_in;
            bcnt_d  = 8'(total_in >> 4);
            addr_d  = message_addr;
            state_d = PAD_WAIT;
          end
        end
      end
      PAD_WAIT: begin
        state_d = PAD_CAP;
      end
      PAD_CAP: begin
        wdata_d = copy_word;
        addr_d  = out_q + i_q;
        we_d    = 1'b1;
        state_d = PAD_NEXT;
      end
      PAD_NEXT: begin
        we_d = 1'b0;
        i_d  = i_q + 16'd1;
        if (i_q + 16'd1 < n_q) begin
          addr_d  = msg_q + i_q + 16'd1;
          state_d = PAD_WAIT;
        end else begin
          addr_d  = out_q + n_q;
          wdata_d = pad_word;
          we_d    = 1'b1;
          j_d     = n_q + 16'd1;
          state_d = PAD_FILL;
        end
      end
      PAD_FILL: begin
        if (j_q == p_q) begin
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = PAD_DONE;
        end else begin
          addr_d  = out_q + j_q;
          wdata_d = pad_word;
          we_d    = 1'b1;
          j_d     = j_q + 16'd1;
        end
      end
      PAD_DONE: begin
        if (!done_q) begin
          done_d = 1'b1;
          err_d  = bad_q;
        end else if (!start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = PAD_IDLE;
        end
      end
      default: begin
        state_d = PAD_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder with a behavioural single-port memory.
// Expected words are hand-derived from the padding rules.
module tb_sha256_padder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = '0;
  logic [15:0] output_addr = '0;
  logic [15:0] num_words = '0;
  logic        done;
  logic        err;
  logic [7:0]  block_count;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [31:0] mem [0:65535];
  int we_cnt = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .num_words      (num_words),
    .done           (done),
    .err            (err),
    .block_count    (block_count),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge mem_clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
    if (mem_we) we_cnt = we_cnt + 1;
  end

  function automatic logic [31:0] exp_copy(input logic [31:0] w);
`ifdef SHA256_PADDER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Start a run; returns edge number of first observed done (-1 on timeout).
  task automatic run(input logic [15:0] n, input logic [15:0] ma,
                     input logic [15:0] oa, output int e_done);
    @(negedge clk);
    num_words = n; message_addr = ma; output_addr = oa; start = 1'b1;
    @(posedge clk);
    e_done = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (done) begin e_done = k; break; end
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({done, err, block_count, mem_we, mem_addr, mem_write_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got done=%b err=%b bc=%0d we=%b addr=%h wd=%h want all 0",
               done, err, block_count, mem_we, mem_addr, mem_write_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_n20(input logic [15:0] oa);
    int e;
    logic [31:0] want;
    run(16'd20, 16'h0000, oa, e);
    total++;
    if (e !== 72) begin bad++; $display("FAIL n20_done_edge got %0d want 72", e); end
    total++;
    if (block_count !== 8'd2 || err !== 1'b0) begin
      bad++; $display("FAIL n20_bc got bc=%0d err=%b want 2 0", block_count, err);
    end
    for (int k = 0; k < 32; k++) begin
      if (k < 20) want = exp_copy(32'(k + 1));
      else if (k == 20) want = 32'h8000_0000;
      else if (k == 31) want = 32'h0000_0280;
      else want = 32'h0;
      total++;
      if (mem[oa + 16'(k)] !== want) begin
        bad++; $display("FAIL n20_word[%0d] got %h want %h", k, mem[oa + 16'(k)], want);
      end
    end
    release_start();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL n20_done_clear got %b want 0", done); end
  endtask

  task automatic test_n13();
    int e;
    run(16'd13, 16'h0000, 16'h0200, e);
    total++;
    if (e !== 42) begin bad++; $display("FAIL n13_done_edge got %0d want 42", e); end
    total++;
    if (block_count !== 8'd1) begin bad++; $display("FAIL n13_bc got %0d want 1", block_count); end
    total++;
    if (mem[16'h0200 + 16'd12] !== exp_copy(32'd13)) begin
      bad++; $display("FAIL n13_last_copy got %h", mem[16'h020C]);
    end
    total++;
    if (mem[16'h020D] !== 32'h8000_0000) begin bad++; $display("FAIL n13_marker got %h want 80000000", mem[16'h020D]); end
    total++;
    if (mem[16'h020E] !== 32'h0) begin bad++; $display("FAIL n13_len_hi got %h want 0", mem[16'h020E]); end
    total++;
    if (mem[16'h020F] !== 32'h0000_01A0) begin bad++; $display("FAIL n13_len_lo got %h want 000001a0", mem[16'h020F]); end
    release_start();
  endtask

  task automatic test_n14_boundary();
    int e;
    run(16'd14, 16'h0000, 16'h0300, e);
    total++;
    if (e !== 60) begin bad++; $display("FAIL n14_done_edge got %0d want 60", e); end
    total++;
    if (block_count !== 8'd2) begin bad++; $display("FAIL n14_bc got %0d want 2", block_count); end
    total++;
    if (mem[16'h030E] !== 32'h8000_0000) begin bad++; $display("FAIL n14_marker got %h want 80000000", mem[16'h030E]); end
    total++;
    if (mem[16'h030F] !== 32'h0) begin bad++; $display("FAIL n14_fill15 got %h want 0", mem[16'h030F]); end
    total++;
    if (mem[16'h031F] !== 32'h0000_01C0) begin bad++; $display("FAIL n14_len_lo got %h want 000001c0", mem[16'h031F]); end
    release_start();
  endtask

  task automatic test_invalid(input logic [15:0] n);
    int e;
    int w0;
    w0 = we_cnt;
    run(n, 16'h0000, 16'h0500, e);
    total++;
    if (e !== 1) begin bad++; $display("FAIL inv%0d_done_edge got %0d want 1", n, e); end
    total++;
    if (err !== 1'b1 || block_count !== 8'd0) begin
      bad++; $display("FAIL inv%0d_err got err=%b bc=%0d want 1 0", n, err, block_count);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL inv%0d_hold got %b want 1", n, done); end
    release_start();
    total++;
    if (we_cnt !== w0 || err !== 1'b0) begin
      bad++; $display("FAIL inv%0d_nowrite got we=%0d err=%b want %0d 0", n, we_cnt, err, w0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    num_words = 16'd20; message_addr = 16'h0000; output_addr = 16'h0400; start = 1'b1;
    @(posedge clk);
    repeat (29) @(posedge clk);
    #1;
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_we_before got %b want 1", mem_we); end
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || done !== 1'b0 || mem_addr !== 16'h0) begin
      bad++; $display("FAIL mid_reset got we=%b done=%b addr=%h want 0 0 0", mem_we, done, mem_addr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_n20(16'h0400);
  endtask

`ifdef SHA256_PADDER_BSWAP_EN
  task automatic test_bswap();
    int e;
    load(16'h0800, 32'h1122_3344);
    run(16'd1, 16'h0800, 16'h0900, e);
    total++;
    if (mem[16'h0900] !== 32'h4433_2211) begin bad++; $display("FAIL bswap_word got %h want 44332211", mem[16'h0900]); end
    total++;
    if (mem[16'h0901] !== 32'h8000_0000) begin bad++; $display("FAIL bswap_marker got %h want 80000000", mem[16'h0901]); end
    total++;
    if (mem[16'h090F] !== 32'h0000_0020) begin bad++; $display("FAIL bswap_len got %h want 00000020", mem[16'h090F]); end
    release_start();
  endtask
`endif

  initial begin
    test_reset();
    for (int k = 0; k < 20; k++) load(16'(k), 32'(k + 1));
    test_n20(16'h0100);
    test_n13();
    test_n14_boundary();
    test_invalid(16'd0);
    test_invalid(16'd21);
    test_reset_mid();
`ifdef SHA256_PADDER_BSWAP_EN
    test_bswap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream preprocessing stage for the SHA-256 hasher. Reads an unpadded message of N 32-bit words from shared single-port memory. Writes a fully padded message of B 512-bit blocks to a second memory region: the message words, then 0x80000000, zero words, and the 64-bit bit-length. The hasher then consumes that region as its message_addr; B is reported so the hasher knows how many blocks to process.

## Interface
- MAX_WORDS, 20: largest accepted N (20 words = 80-byte Bitcoin header = 2 blocks)
- clk  in  1  clock; also driven out as mem_clk
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level request, sampled in IDLE
- message_addr  in  16  word address of raw message
- output_addr  in  16  word address of padded output
- num_words  in  16  N, message length in 32-bit words
- done  out  1  high in DONE; held until start is low
- err  out  1  high with done when N==0 or N>MAX_WORDS (nothing written)
- block_count  out  8  B, valid while done=1
- mem_clk  out  1  = clk
- mem_we  out  1  registered write enable
- mem_addr  out  16  registered address
- mem_write_data  out  32  registered write data
- mem_read_data  in  32  valid the cycle after memory samples mem_addr

## Operation
- B = (N+3+15)>>4 (N data words + 1 pad marker + 2 length words, rounded up to 16). P = 16·B.
- States:
  - IDLE: on start, latch inputs; if N invalid go to DONE with err=1; else mem_addr<=message_addr, go to WAIT.
  - WAIT: always go to CAP.
  - CAP: mem_write_data<=mem_read_data, mem_addr<=output_addr+i, mem_we<=1, go to NEXT.
  - NEXT: mem_we<=0, i<=i+1. If i+1<N: mem_addr<=message_addr+i+1, go to WAIT. Else go to PAD and issue pad word N at this edge.
  - PAD: one write per cycle at output_addr+j, j=N..P−1.
    - j==N: data 0x80000000.
    - j==P−2: data 0 (length high word; always 0 because N·32 < 2^32).
    - j==P−1: data N·32, i.e. {num_words,5'b0}, zero-extended to 32 bits.
    - Otherwise 0.
  - After word P−1: mem_we<=0, done<=1, go to DONE.
  - DONE: hold done/err/block_count; on start==0 go to IDLE and clear done and err.
- All address arithmetic is 16-bit and wraps modulo 2^16. No error is flagged on wrap.
- Inputs are latched at start. Changes to them mid-operation are ignored.

## Timing
- Reset values: done=0, err=0, block_count=0, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE. Assertion is immediate (async), including mid-operation; the memory contents written so far are left as-is.
- The start-sampling edge is edge 0. Read i is issued at edge 3i and its write at edge 3i+2.
- Pad writes occur at edges 3N … 3N+P−N−1.
- done rises at edge 3N+P−N. Examples: N=20 → edge 72; N=13 → edge 42.
- An invalid N produces done=err=1 at edge 1.
- start held high in DONE keeps done high, so there is no retrigger until start falls.
- mem_we is never high for two consecutive cycles in the copy phase. In the PAD phase it is high every cycle.

## Configuration
- SHA256_PADDER_BSWAP_EN defined: each copied message word is byte-reversed ({b0,b1,b2,b3}) before writing, for little-endian source data such as the raw Bitcoin header. Pad and length words are never swapped.
- SHA256_PADDER_BSWAP_EN undefined: words are copied verbatim.

## Structure
- Shared package sha256_pkg holds:
  - SHA256_PAD_MARKER = 32'h8000_0000
  - SHA256_BLOCK_WORDS = 16
  - the padder state enum
- The hasher uses the same package constants.
- One sub-module, sha256_pad_gen: combinational; given N and j, returns the pad word. The FSM calls it during PAD.

## Test plan
- N=20, message words 0x00000001..0x00000014 at 0x0000, output_addr=0x0100:
  - output[0..19] equals input; [20]=0x80000000; [21..29]=0; [30]=0; [31]=0x00000280
  - block_count=2; done at edge 72.
- N=13: [13]=0x80000000, [14]=0, [15]=0x000001A0, block_count=1.
- N=14 (boundary): block_count=2, [14]=0x80000000, [31]=0x000001C0.
- N=0 and N=21: err=1, done=1 at edge 1, block_count=0, mem_we never asserted.
- Reset pulsed at edge 30 of an N=20 run: mem_we=0 and done=0 immediately. A fresh start then completes normally with the same results as scenario 1.
- With SHA256_PADDER_BSWAP_EN, input 0x11223344 → output 0x44332211; pad marker unchanged at 0x80000000.
